// File: rtl/gray_frame_writer_if.sv
// Pixel stream in (valid/ready with sof/eol markers) and frame-buffer write port out.
// Parameterised on the frame-buffer address width; must match the writer instance.
interface gray_frame_writer_if #(
    parameter int ADDR_W = 18
);
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output pix_valid, pix_data, pix_sof, pix_eol,
        input  pix_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, pix_eol,
        output pix_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/gray_frame_writer.sv
// Raster-order writer of one gray frame into a RAM; write lands one cycle after accept.
// pix_ready is a registered state decode only, so upstream stalls never reach it combinationally.
module gray_frame_writer #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int ADDR_W = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    gray_frame_writer_if.slave pix,
    output logic [15:0]        x_pos,
    output logic [15:0]        y_pos,
    output logic               busy,
    output logic               frame_done,
    output logic               err_sync
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;

    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    state_t            state_q, state_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              accept;
    logic              wr_go;
    logic [15:0]       bx, by;
    logic [ADDR_W-1:0] ba;
    logic              last_pix;

    assign accept = pix.pix_valid & rdy_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        err_d    = err_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wr_go    = 1'b0;
        bx       = x_q;
        by       = y_q;
        ba       = addr_q;
        last_pix = 1'b0;

        // bx/by/ba select the position this pixel lands on; a sof restarts it at the origin.
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (accept && pix.pix_sof) begin
                    wr_go = 1'b1;
                    bx    = '0;
                    by    = '0;
                    ba    = '0;
                end
            end
            WRITE: begin
                if (accept) begin
                    wr_go = 1'b1;
                    if (pix.pix_sof && (x_q != 16'd0 || y_q != 16'd0)) begin
                        err_d = 1'b1;
                        bx    = '0;
                        by    = '0;
                        ba    = '0;
                    end else if (pix.pix_eol != (x_q == X_LAST)) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_go) begin
            last_pix = (bx == X_LAST) && (by == Y_LAST);
            we_d     = 1'b1;
            waddr_d  = ba;
            wdata_d  = pix.pix_data;
            done_d   = last_pix;
            if (bx == X_LAST) begin
                x_d = '0;
                y_d = by + 16'd1;
            end else begin
                x_d = bx + 16'd1;
                y_d = by;
            end
            // The address counter parks on the final pixel rather than running past the frame.
            addr_d  = last_pix ? ba : ba + ADDR_W'(1);
            state_d = last_pix ? DONE : WRITE;
        end

        rdy_d = (state_d == WAIT_SOF) || (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pix.pix_ready = rdy_q;
    assign pix.mem_we    = we_q;
    assign pix.mem_addr  = waddr_q;
    assign pix.mem_wdata = wdata_q;
    assign x_pos         = x_q;
    assign y_pos         = y_q;
    assign busy          = rdy_q;
    assign frame_done    = done_q;
    assign err_sync      = err_q;
endmodule

// File: tb/tb_gray_frame_writer.sv
// Bench for gray_frame_writer on a 4x2 frame: a per-pixel-index model plus literal checks per scenario.
module tb_gray_frame_writer;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x_pos, y_pos;
    logic        busy, frame_done, err_sync;

    gray_frame_writer_if #(.ADDR_W(3)) gif ();

    gray_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix        (gif),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .busy       (busy),
        .frame_done (frame_done),
        .err_sync   (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position is a single linear pixel index n; x = n % W, y = n / W.
    typedef enum int {P_IDLE, P_WAIT, P_RUN, P_DONE} phase_t;
    phase_t     phase = P_IDLE;
    int         m_n = 0;
    bit         m_err = 0, m_we = 0, m_done = 0, m_rdy = 0, m_acc = 0;
    int         m_addr = 0;
    logic [7:0] m_data = 8'h00;
    bit         chk_en = 0;

    task automatic m_write(input int i);
        m_we   = 1'b1;
        m_addr = i;
        m_data = gif.pix_data;
        m_n    = i + 1;
        if (i == NPIX - 1) begin
            phase  = P_DONE;
            m_done = 1'b1;
        end else begin
            phase = P_RUN;
        end
    endtask

    always @(posedge clk) begin
        m_acc  = gif.pix_valid && m_rdy;
        m_we   = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            phase = P_IDLE;
            m_n   = 0;
            m_err = 1'b0;
        end else begin
            case (phase)
                P_IDLE: if (start) begin phase = P_WAIT; m_n = 0; m_err = 1'b0; end
                P_WAIT: if (m_acc && gif.pix_sof) m_write(0);
                P_RUN: if (m_acc) begin
                    if (gif.pix_sof && m_n != 0) begin
                        m_err = 1'b1;
                        m_write(0);
                    end else begin
                        if (gif.pix_eol != ((m_n % W) == W - 1)) m_err = 1'b1;
                        m_write(m_n);
                    end
                end
                default: phase = P_IDLE;
            endcase
        end
        m_rdy = (phase == P_WAIT) || (phase == P_RUN);
    end

    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    bit          log_done[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_we", 32'(gif.mem_we), 32'(m_we));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("err_sync", 32'(err_sync), 32'(m_err));
            check("pix_ready", 32'(gif.pix_ready), 32'(m_rdy));
            check("busy", 32'(busy), 32'(m_rdy));
            check("x_pos", 32'(x_pos), 32'(m_n % W));
            check("y_pos", 32'(y_pos), 32'(m_n / W));
            if (m_we) begin
                check("mem_addr", 32'(gif.mem_addr), 32'(m_addr));
                check("mem_wdata", 32'(gif.mem_wdata), 32'(m_data));
            end
            if (gif.mem_we === 1'b1) begin
                log_a.push_back(32'(gif.mem_addr));
                log_d.push_back(32'(gif.mem_wdata));
                log_done.push_back(frame_done);
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    logic [7:0] pd[$];
    bit         ps[$];
    bit         pe[$];

    task automatic clear_all();
        pd.delete(); ps.delete(); pe.delete();
        log_a.delete(); log_d.delete(); log_done.delete();
        done_cnt = 0;
    endtask

    task automatic add_frame(input logic [7:0] base);
        for (int i = 0; i < NPIX; i++) begin
            pd.push_back(base + 8'(i));
            ps.push_back(i == 0);
            pe.push_back((i % W) == W - 1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Valid pattern 1,0,0,1 repeating when stalled.
    task automatic drive_stream(input bit stall);
        int         i;
        int         k;
        bit         v;
        bit         took;
        logic [3:0] pat;
        i = 0; k = 0; pat = 4'b1001;
        while (i < pd.size()) begin
            v = stall ? pat[k % 4] : 1'b1;
            gif.pix_valid = v;
            gif.pix_data  = pd[i];
            gif.pix_sof   = ps[i];
            gif.pix_eol   = pe[i];
            @(negedge clk);
            took = v && (gif.pix_ready === 1'b1);
            @(posedge clk); #1;
            if (took) i++;
            k++;
            if (k > 300) begin
                n_tests++; n_fail++;
                $display("FAIL stream_timeout: actual=%0d accepted required=%0d", i, pd.size());
                break;
            end
        end
        gif.pix_valid = 1'b0;
        gif.pix_sof   = 1'b0;
        gif.pix_eol   = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (phase != P_IDLE && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: actual=busy required=idle");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_addrs(input string nm, input int first);
        check({nm, "_count"}, 32'(log_a.size()), 32'(first + NPIX));
        for (int i = 0; i < NPIX; i++)
            check({nm, "_addr"}, log_a[first + i], 32'(i));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        gif.pix_valid = 1'b0; gif.pix_data = 8'h00; gif.pix_sof = 1'b0; gif.pix_eol = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_we", 32'(gif.mem_we), 32'd0);
        check("rst_ready", 32'(gif.pix_ready), 32'd0);
        check("rst_xy", {x_pos, y_pos}, 32'd0);
        check("rst_flags", {29'd0, busy, frame_done, err_sync}, 32'd0);
        @(posedge clk); #1;

        // Full frame, continuous valid
        clear_all(); add_frame(8'h10);
        pulse_start(); drive_stream(1'b0); wait_idle();
        check_addrs("full", 0);
        for (int i = 0; i < NPIX; i++) check("full_data", log_d[i], 32'h10 + 32'(i));
        check("full_done_at_7", 32'(log_done[7]), 32'd1);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_err", 32'(err_sync), 32'd0);
        check("full_ready_after", 32'(gif.pix_ready), 32'd0);

        // Pre-frame junk
        clear_all();
        for (int i = 0; i < 3; i++) begin pd.push_back(8'hA0 + 8'(i)); ps.push_back(0); pe.push_back(0); end
        add_frame(8'h10);
        pulse_start(); drive_stream(1'b0); wait_idle();
        check_addrs("junk", 0);
        check("junk_first_data", log_d[0], 32'h10);

        // Stalls
        clear_all(); add_frame(8'h10);
        pulse_start(); drive_stream(1'b1); wait_idle();
        check_addrs("stall", 0);
        check("stall_last_data", log_d[7], 32'h17);
        check("stall_done_cnt", 32'(done_cnt), 32'd1);

        // Bad eol on the 2nd pixel
        clear_all(); add_frame(8'h10); pe[1] = 1'b1;
        pulse_start(); drive_stream(1'b0); wait_idle();
        check_addrs("badeol", 0);
        check("badeol_err", 32'(err_sync), 32'd1);
        check("badeol_done_cnt", 32'(done_cnt), 32'd1);

        // Mid-frame sof on the 6th pixel
        clear_all();
        for (int i = 0; i < 5; i++) begin pd.push_back(8'h10 + 8'(i)); ps.push_back(i == 0); pe.push_back(i == 3); end
        pd.push_back(8'h55); ps.push_back(1); pe.push_back(0);
        for (int i = 0; i < 7; i++) begin pd.push_back(8'h60 + 8'(i)); ps.push_back(0); pe.push_back(i == 2 || i == 6); end
        pulse_start(); drive_stream(1'b0); wait_idle();
        check("resync_count", 32'(log_a.size()), 32'd13);
        check("resync_addr", log_a[5], 32'd0);
        check("resync_data", log_d[5], 32'h55);
        check("resync_last_addr", log_a[12], 32'd7);
        check("resync_last_data", log_d[12], 32'h66);
        check("resync_done_late", {31'd0, log_done[11]}, 32'd0);
        check("resync_done_cnt", 32'(done_cnt), 32'd1);
        check("resync_err", 32'(err_sync), 32'd1);

        // Reset mid-frame, with err_sync already set by a bad eol
        clear_all();
        for (int i = 0; i < 4; i++) begin pd.push_back(8'h30 + 8'(i)); ps.push_back(i == 0); pe.push_back(i == 1 || i == 3); end
        pulse_start(); drive_stream(1'b0);
        gif.pix_valid = 1'b1; gif.pix_data = 8'h34; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; gif.pix_valid = 1'b0;
        @(negedge clk);
        check("mrst_mem_we", 32'(gif.mem_we), 32'd0);
        check("mrst_err", 32'(err_sync), 32'd0);
        check("mrst_ready", 32'(gif.pix_ready), 32'd0);
        check("mrst_xy", {x_pos, y_pos}, 32'd0);
        check("mrst_busy_done", {30'd0, busy, frame_done}, 32'd0);
        check("mrst_writes", 32'(log_a.size()), 32'd4);
        @(posedge clk); #1;
        pd.delete(); ps.delete(); pe.delete();
        add_frame(8'h20);
        pulse_start(); drive_stream(1'b0); wait_idle();
        check_addrs("after_rst", 4);
        check("after_rst_data0", log_d[4], 32'h20);
        check("after_rst_err", 32'(err_sync), 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gray_frame_writer.md
Name: gray_frame_writer

Overview:
- Sink end of the grayscale pixel stream produced by rgb_to_grayscale.
- Accepts one 8-bit gray pixel per handshake and writes it, in raster order, into a frame buffer through a simple synchronous RAM write port.
- Tracks column/row position, checks stream framing markers, and signals frame completion so the downstream edge-detection stages can start.

Parameters:
- WIDTH, 512, pixels per line.
- HEIGHT, 512, lines per frame.
- ADDR_W, 18, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms capture of one frame; ignored unless in IDLE.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  writer can accept a pixel.
- pix_data  in  8  gray pixel value.
- pix_sof  in  1  start of frame; qualified by pix_valid.
- pix_eol  in  1  end of line; qualified by pix_valid.
- mem_we  out  1  frame-buffer write enable.
- mem_addr  out  ADDR_W  frame-buffer write address, y*WIDTH+x.
- mem_wdata  out  8  frame-buffer write data.
- x_pos  out  16  column of the next expected pixel.
- y_pos  out  16  row of the next expected pixel.
- busy  out  1  high in WAIT_SOF or WRITE.
- frame_done  out  1  one-cycle pulse when the last pixel is written.
- err_sync  out  1  sticky framing error; cleared by rst or start.

Behaviour:
- Reset values: all outputs 0, state IDLE, and x/y counters 0.
- accept = pix_valid & pix_ready.
- pix_ready is a registered function of state only: 1 in WAIT_SOF and WRITE, 0 otherwise. It never depends combinationally on pix_valid.
- States:
  - IDLE: on start, clear err_sync, clear x/y, go to WAIT_SOF.
  - WAIT_SOF:
    - Accepted pixels without pix_sof are discarded (no write).
    - An accepted pixel with pix_sof is pixel (0,0): write it and go to WRITE.
  - WRITE:
    - Each accepted pixel is written at the current (x,y), then x increments.
    - At x==WIDTH-1, x wraps to 0 and y increments.
    - Accepting pixel (WIDTH-1, HEIGHT-1) moves the state to DONE.
  - DONE: lasts one cycle, then go to IDLE. pix_ready is 0.
- Write latency: for a pixel accepted in cycle T, mem_we=1 in cycle T+1 with mem_addr/mem_wdata registered from cycle T. mem_we is 0 in every other cycle. Back-to-back accepts give back-to-back writes.
- frame_done is asserted in the same cycle as the final mem_we (T+1 of the last accept).
- Address arithmetic:
  - mem_addr is a running counter that increments per write.
  - It is not a multiplier; it must equal y*WIDTH+x.
  - No wrap past WIDTH*HEIGHT-1.
- x_pos/y_pos reflect the counters after the update of cycle T, i.e. they are valid in T+1.
- Framing checks in WRITE, each setting err_sync (sticky):
  - pix_eol=1 with x!=WIDTH-1: eol is ignored and counting continues.
  - pix_eol=0 with x==WIDTH-1: the line still wraps on count.
  - pix_sof=1 with (x,y)!=(0,0): resync. This pixel is written at address 0 and x=1, y=0; the frame restarts.
- pix_valid low stalls: counters hold, no write.
- start while not in IDLE: ignored.
- rst mid-frame:
  - Next cycle: IDLE, all outputs 0.
  - A pending registered write is dropped (mem_we=0).
  - err_sync is cleared.
- pix_data and flags are don't-care when pix_valid=0.

Test Plan:
- Use WIDTH=4, HEIGHT=2 throughout.
- Full frame, continuous valid:
  - Stimulus: start, then 8 pixels 0x10..0x17, sof on the first, eol on the 4th and 8th.
  - Required: writes to addr 0..7 with data 0x10..0x17 on consecutive cycles; frame_done coincides with the addr-7 write; err_sync=0; pix_ready=0 after DONE.
- Pre-frame junk:
  - Stimulus: start, then 3 valid pixels without sof, then the frame from the previous test.
  - Required: no mem_we for the junk; first write is addr 0 data 0x10.
- Stalls:
  - Stimulus: same frame with pix_valid toggled 1,0,0,1 in a repeating pattern.
  - Required: identical address/data sequence; mem_we only the cycle after each accept; x/y hold during gaps.
- Bad eol:
  - Stimulus: pix_eol on the 2nd pixel.
  - Required: err_sync=1 from the cycle after; addresses still 0..7; frame_done still pulses.
- Mid-frame sof:
  - Stimulus: sof asserted again on the 6th pixel (value 0x55).
  - Required: write addr 0 data 0x55, err_sync=1; frame_done only after 7 further pixels (8 pixels counted from the resync).
- Reset mid-frame:
  - Stimulus: rst after 5 accepts, then start and a clean frame.
  - Required: all outputs 0 the cycle after rst; no write for the 5th pixel; the new frame writes 0..7 normally with err_sync=0.
